// File: rtl/pontuacao_pkg.sv
// Shared definitions for the Batalha Naval score unit.
//   - cell codes stored in each 2-bit board cell
//   - FSM state encoding
//   - board / score geometry constants
//   - cell_at(): extracts cell idx from a packed board
package pontuacao_pkg;

    localparam int unsigned N_CELLS = 32;
    localparam int unsigned CELL_W  = 2;
    localparam int unsigned ADDR_W  = $clog2(N_CELLS);
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned MEM_W   = N_CELLS * CELL_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

    typedef enum logic [CELL_W-1:0] {
        AGUA           = 2'b00,
        NAVIO          = 2'b01,
        TIRO_AGUA      = 2'b10,
        NAVIO_ATINGIDO = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic cell_t cell_at(input logic [MEM_W-1:0] mem,
                                      input logic [ADDR_W-1:0] idx);
        return cell_t'(mem[idx*CELL_W +: CELL_W]);
    endfunction

endpackage

// File: rtl/pontuacao_if.sv
// Bus between the game-memory side and the score unit.
//   enable       : start request (master -> slave)
//   memoriaP1/P2 : packed 32x2-bit boards (master -> slave)
//   ready        : scores valid (slave -> master)
//   pontuacao_P1 : hits landed on the P2 board (slave -> master)
//   pontuacao_P2 : hits landed on the P1 board (slave -> master)
//   addr         : cell currently examined (slave -> master)
interface pontuacao_if;
    import pontuacao_pkg::*;

    logic               enable;
    logic [MEM_W-1:0]   memoriaP1;
    logic [MEM_W-1:0]   memoriaP2;
    logic               ready;
    logic [SCORE_W-1:0] pontuacao_P1;
    logic [SCORE_W-1:0] pontuacao_P2;
    logic [ADDR_W-1:0]  addr;

    modport master (
        output enable, memoriaP1, memoriaP2,
        input  ready, pontuacao_P1, pontuacao_P2, addr
    );

    modport slave (
        input  enable, memoriaP1, memoriaP2,
        output ready, pontuacao_P1, pontuacao_P2, addr
    );

endinterface

// File: rtl/pontuacao_acc.sv
// Saturating hit accumulator, one per player.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (wins over inc)
//   inc        : add one, sticking at all-ones
//   count_next : value the register takes at the next edge; lets the
//                caller capture a total that includes the current cell
module pontuacao_acc
    import pontuacao_pkg::*;
#(
    parameter int unsigned WIDTH = SCORE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count_next
);

    logic [WIDTH-1:0] count;

    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (inc && (count != '1))
            count_next = count + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/pontuacao.sv
// Batalha Naval score unit. On enable, walks both boards one cell per
// clock and counts NAVIO_ATINGIDO cells; a player's score is the hits
// found on the opponent's board.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pontuacao_if slave (enable, boards in; ready, scores,
//                addr out). All outputs are registered.
module pontuacao
    import pontuacao_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    pontuacao_if.slave   bus
);

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic               ready_q;
    logic [SCORE_W-1:0] score1_q;
    logic [SCORE_W-1:0] score2_q;

    logic               acc_clear;
    logic               hit1;
    logic               hit2;
    logic [SCORE_W-1:0] acc1_next;
    logic [SCORE_W-1:0] acc2_next;

    // Accumulators are cleared on the edge that starts a scan, so a scan
    // always begins from zero regardless of what the previous one left.
    always_comb begin
        acc_clear = (state != SCAN) && bus.enable;
        hit1      = (state == SCAN) &&
                    (cell_at(bus.memoriaP2, addr_q) == NAVIO_ATINGIDO);
        hit2      = (state == SCAN) &&
                    (cell_at(bus.memoriaP1, addr_q) == NAVIO_ATINGIDO);
    end

    pontuacao_acc #(.WIDTH(SCORE_W)) u_acc_p1 (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .inc        (hit1),
        .count_next (acc1_next)
    );

    pontuacao_acc #(.WIDTH(SCORE_W)) u_acc_p2 (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .inc        (hit2),
        .count_next (acc2_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            score1_q <= '0;
            score2_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        addr_q <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (addr_q == LAST_ADDR) begin
                        // acc*_next already includes the last cell
                        score1_q <= acc1_next;
                        score2_q <= acc2_next;
                        ready_q  <= 1'b1;
                        addr_q   <= '0;
                        state    <= DONE;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.enable) begin
                        ready_q <= 1'b0;
                        addr_q  <= '0;
                        state   <= SCAN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    addr_q  <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready        = ready_q;
    assign bus.pontuacao_P1 = score1_q;
    assign bus.pontuacao_P2 = score2_q;
    assign bus.addr         = addr_q;

endmodule

// File: tb/tb_pontuacao.sv
// Directed bench for pontuacao with an expected-score scoreboard.
module tb_pontuacao;
    import pontuacao_pkg::*;

    typedef struct {
        logic [SCORE_W-1:0] p1;
        logic [SCORE_W-1:0] p2;
    } exp_t;

    logic clk;
    logic reset;
    pontuacao_if bus ();

    pontuacao dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    logic [SCORE_W-1:0] prev_p1 = '0;
    logic [SCORE_W-1:0] prev_p2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count NAVIO_ATINGIDO cells, clamp at 15.
    function automatic logic [SCORE_W-1:0] model_score(input logic [MEM_W-1:0] mem);
        int unsigned cnt = 0;
        for (int unsigned k = 0; k < N_CELLS; k++)
            if (mem[2*k +: 2] == 2'b11) cnt++;
        if (cnt > 15) cnt = 15;
        return SCORE_W'(cnt);
    endfunction

    function automatic logic [MEM_W-1:0] fill_cells(input logic [1:0] code);
        logic [MEM_W-1:0] m;
        for (int unsigned k = 0; k < N_CELLS; k++) m[2*k +: 2] = code;
        return m;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.p1 = model_score(bus.memoriaP2);
        e.p2 = model_score(bus.memoriaP1);
        sb_q.push_back(e);
    endtask

    // Called right after the edge that sampled enable. Counts edges until
    // ready, checks held scores mid-scan, then scores against the scoreboard.
    task automatic wait_ready(input bit check_addr);
        int   n = 0;
        exp_t e;
        while (bus.ready !== 1'b1 && n < 40) begin
            if (check_addr) check("addr_step", 32'(bus.addr), 32'(n));
            if (n == 16) begin
                check("held_p1", 32'(bus.pontuacao_P1), 32'(prev_p1));
                check("held_p2", 32'(bus.pontuacao_P2), 32'(prev_p2));
            end
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd32);
        check("addr_done", 32'(bus.addr), 32'd0);
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("score_p1", 32'(bus.pontuacao_P1), 32'(e.p1));
            check("score_p2", 32'(bus.pontuacao_P2), 32'(e.p2));
            prev_p1 = e.p1;
            prev_p2 = e.p2;
        end
    endtask

    task automatic pulse_start();
        push_expected();
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        check("start_ready", 32'(bus.ready), 32'd0);
        check("start_addr", 32'(bus.addr), 32'd0);
    endtask

    logic [MEM_W-1:0] mem_a_p1, mem_a_p2;

    initial begin
        bus.enable    = 1'b0;
        bus.memoriaP1 = '0;
        bus.memoriaP2 = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_p1", 32'(bus.pontuacao_P1), 32'd0);
        check("rst_p2", 32'(bus.pontuacao_P2), 32'd0);

        // Test 3 board: P1 score 3, P2 score 1, address walk checked
        mem_a_p2 = fill_cells(2'b01);
        mem_a_p2[1:0]   = 2'b11;
        mem_a_p2[11:10] = 2'b11;
        mem_a_p2[63:62] = 2'b11;
        mem_a_p1 = '0;
        mem_a_p1[15:14] = 2'b11;
        mem_a_p1[17:16] = 2'b10;
        bus.memoriaP1 = mem_a_p1;
        bus.memoriaP2 = mem_a_p2;
        pulse_start();
        wait_ready(1'b1);
        check("t3_p1_const", 32'(bus.pontuacao_P1), 32'd3);
        check("t3_p2_const", 32'(bus.pontuacao_P2), 32'd1);

        // DONE holds without enable
        repeat (5) tick();
        check("done_hold_ready", 32'(bus.ready), 32'd1);
        check("done_hold_p1", 32'(bus.pontuacao_P1), 32'd3);

        // Test 1: async reset at cycle 10 of a scan
        pulse_start();
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.ready), 32'd0);
        check("midrst_addr", 32'(bus.addr), 32'd0);
        check("midrst_p1", 32'(bus.pontuacao_P1), 32'd0);
        check("midrst_p2", 32'(bus.pontuacao_P2), 32'd0);
        sb_q.delete();
        prev_p1 = '0;
        prev_p2 = '0;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("idle_addr", 32'(bus.addr), 32'd0);
        check("idle_ready", 32'(bus.ready), 32'd0);

        // Test 2: empty boards
        bus.memoriaP1 = '0;
        bus.memoriaP2 = '0;
        pulse_start();
        wait_ready(1'b0);

        // Test 4: every cell hit -> saturate
        bus.memoriaP1 = '1;
        bus.memoriaP2 = '1;
        pulse_start();
        wait_ready(1'b0);

        // Test 5: enable toggled mid-scan has no effect
        bus.memoriaP1 = mem_a_p1;
        bus.memoriaP2 = mem_a_p2;
        pulse_start();
        repeat (4) tick();
        bus.enable = 1'b1;
        tick();
        tick();
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        // 8 edges already consumed; remaining must be 24
        begin
            int n = 0;
            exp_t e;
            while (bus.ready !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("toggle_latency", 32'(n), 32'd24);
            e = sb_q.pop_front();
            check("toggle_p1", 32'(bus.pontuacao_P1), 32'(e.p1));
            check("toggle_p2", 32'(bus.pontuacao_P2), 32'(e.p2));
            prev_p1 = e.p1;
            prev_p2 = e.p2;
        end
        // rescan from DONE with new boards
        tick();
        bus.memoriaP1 = fill_cells(2'b11);
        bus.memoriaP1[9:0] = '0;
        bus.memoriaP2 = '0;
        bus.memoriaP2[41:40] = 2'b11;
        pulse_start();
        wait_ready(1'b0);

        // Test 6: enable held high -> back-to-back scans
        bus.memoriaP1 = '1;
        bus.memoriaP2 = mem_a_p2;
        push_expected();
        bus.enable = 1'b1;
        tick();
        wait_ready(1'b0);
        bus.memoriaP1 = mem_a_p1;
        bus.memoriaP2 = fill_cells(2'b10);
        push_expected();
        tick();
        check("b2b_ready_drop", 32'(bus.ready), 32'd0);
        check("b2b_addr", 32'(bus.addr), 32'd0);
        wait_ready(1'b0);
        bus.enable = 1'b0;
        tick();
        check("b2b_end_ready", 32'(bus.ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
